axi_read_arbiter: RTL
=====================

Name: axi_read_arbiter

Overview:
Parametrised arbiter for the shared AXI read channel between N cache miss engines (instruction, data, and future ports such as a prefetcher or a second hart's caches). Replaces the plain OR of per-cache start-read pulses with:
- per-port request latching;
- fixed-priority or round-robin selection;
- one outstanding burst at a time, owned by one port;
- per-port completion steering;
- an optional watchdog timeout on missing r_last.

Sits between the control unit's cache FSMs and the AXI master read interface.

Parameters:
N_PORTS, 2, number of requesting ports (>=1); port 0 = instruction cache, port 1 = data cache.
RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
TIMEOUT_CYCLES, 0, watchdog limit in cycles while waiting for r_last; 0 disables the watchdog.
CNT_W, 16, watchdog counter width; TIMEOUT_CYCLES must be < 2**CNT_W.

Ports:
clk  input  1  system clock
arstn  input  1  asynchronous active-low reset
i_start_read  input  N_PORTS  one-cycle start-read pulse per port from its cache FSM
i_read_last_axi  input  1  AXI read last beat (r_last accepted)
o_start_read_axi  output  1  one-cycle pulse launching a burst on the AXI master
o_grant  output  N_PORTS  one-hot owner of the current burst; all-zero when idle
o_grant_id  output  max(1,$clog2(N_PORTS))  binary index of the owner, valid when o_busy
o_busy  output  1  burst in flight (START or WAIT state)
o_read_last  output  N_PORTS  one-cycle pulse to the owner when its burst completes
o_pending  output  N_PORTS  latched, not-yet-granted requests
o_timeout  output  1  one-cycle pulse when the watchdog expires
o_timeout_sticky  output  1  set on any timeout; cleared only by reset

Behaviour:
- Reset (arstn low, asynchronous):
  - state = IDLE; pending, grant, grant_id, RR pointer, watchdog counter and sticky all 0.
  - All outputs 0.
  - Reset mid-burst abandons the burst silently; no o_read_last is issued.
- Request latching: pending[k] <= pending[k] | i_start_read[k], except the bit cleared by a grant in the same cycle.
  - A pulse on an already-pending port is absorbed (no count, no duplicate burst).
  - A pulse from the current owner during START/WAIT sets pending: it is queued as a new burst.
- Arbitration (evaluated in IDLE on the registered pending vector only, so a same-cycle pulse is not granted until the next cycle):
  - RR_MODE=0: lowest-index pending port wins.
  - RR_MODE=1: search starts at the RR pointer, wraps modulo N_PORTS. On each grant to port k, pointer <= (k+1) mod N_PORTS.
  - N_PORTS=1: the single port always wins.
- FSM:
  - IDLE: if any pending, latch winner into grant/grant_id, clear its pending bit, go to START. Otherwise stay.
  - START: o_start_read_axi = 1 for exactly this cycle, watchdog counter cleared; go to WAIT.
  - WAIT: counter increments each cycle.
    - On i_read_last_axi: o_read_last[grant_id] = 1 (combinational, same cycle); next state IDLE; grant cleared on entry to IDLE.
    - Else if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: o_timeout pulses, sticky set, next state IDLE, no o_read_last.
    - If last and timeout coincide, last wins; no timeout is flagged.
- i_read_last_axi in IDLE or START is ignored.
- Latency:
  - Pulse at cycle t with arbiter idle: pending at t+1, grant latched at t+1 (IDLE), o_start_read_axi at t+2.
  - Back-to-back bursts have one IDLE cycle between o_read_last and the next START.
- o_busy = (state != IDLE). o_grant is zero in IDLE.
- Counter saturates at 2**CNT_W-1 when the watchdog is disabled (no wrap).

Test Plan:
- Single request: N_PORTS=2, pulse i_start_read=2'b01 at cycle 0 -> o_pending=01 at cycle 1; o_start_read_axi pulse at cycle 2 with o_grant=01, o_grant_id=0; i_read_last_axi at cycle 6 -> o_read_last=01 in cycle 6, o_busy=0 at cycle 7.
- Simultaneous requests, RR_MODE=0: pulse 2'b11 -> port 0 served first, then port 1 starts one IDLE cycle after port 0's last.
  - Repeat with a port 0 re-request during port 1's burst -> port 1 completes, then port 0 is served.
- Round-robin fairness: RR_MODE=1, N_PORTS=3, all ports re-pulse continuously -> grant order 0,1,2,0,1,2; no port is granted twice before the others.
- Watchdog: TIMEOUT_CYCLES=8, no r_last after START -> o_timeout pulse exactly 8 cycles after START, o_timeout_sticky=1, o_read_last stays 0, FSM IDLE.
  - Then r_last on the 8th cycle in a fresh burst -> o_read_last pulse, no timeout.
- Duplicate / stray events:
  - Double pulse on port 1 while pending -> only one burst.
  - i_read_last_axi while IDLE -> no outputs change.
- Reset mid-WAIT: assert arstn low during a port 1 burst -> all outputs 0 immediately; after release no o_read_last and no pending requests.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI read channel between N_PORTS cache miss
// engines. Start-read pulses are latched per port, one owner is selected by
// fixed priority or round-robin, the burst is launched, and completion is
// steered back to the owner. An optional watchdog abandons a burst whose
// r_last never arrives.
module axi_read_arbiter #(
  parameter int N_PORTS        = 2,
  parameter int RR_MODE        = 0,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 16,
  localparam int ID_W          = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic               clk,
  input  logic               arstn,
  input  logic [N_PORTS-1:0] i_start_read,
  input  logic               i_read_last_axi,
  output logic               o_start_read_axi,
  output logic [N_PORTS-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_id,
  output logic               o_busy,
  output logic [N_PORTS-1:0] o_read_last,
  output logic [N_PORTS-1:0] o_pending,
  output logic               o_timeout,
  output logic               o_timeout_sticky
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_PORTS-1:0] pending_q;
  logic [N_PORTS-1:0] grant_q;
  logic [ID_W-1:0]    grant_id_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sticky_q;

  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    cand;
  logic [ID_W-1:0]    rr_next;
  logic [N_PORTS-1:0] clear_mask;
  logic               grant_set;
  logic               start_pulse;
  logic               last_ok;
  logic               timeout_hit;

  // Winner search over the registered pending vector (never the raw pulses).
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      cand = (RR_MODE != 0) ? ID_W'((int'(rr_ptr_q) + i) % N_PORTS) : ID_W'(i);
      if (!win_found && pending_q[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign rr_next    = (win_id == ID_W'(N_PORTS - 1)) ? '0 : win_id + 1'b1;
  assign clear_mask = grant_set ? (N_PORTS'(1) << win_id) : '0;

  // Next-state and per-cycle strobes; r_last beats the watchdog on a tie.
  always_comb begin
    state_d     = state_q;
    grant_set   = 1'b0;
    start_pulse = 1'b0;
    last_ok     = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_set = 1'b1;
          state_d   = S_START;
        end
      end
      S_START: begin
        start_pulse = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (i_read_last_axi) begin
          last_ok = 1'b1;
          state_d = S_IDLE;
        end else if (TIMEOUT_CYCLES != 0 &&
                     cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Request latching; a grant clears its own bit even if re-pulsed that cycle.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) pending_q <= '0;
    else        pending_q <= (pending_q | i_start_read) & ~clear_mask;
  end

  // Owner bookkeeping: latch winner on grant, drop ownership on return to IDLE.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      grant_q    <= '0;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
    end else if (grant_set) begin
      grant_q    <= N_PORTS'(1) << win_id;
      grant_id_q <= win_id;
      rr_ptr_q   <= rr_next;
    end else if (state_d == S_IDLE) begin
      grant_q    <= '0;
      grant_id_q <= '0;
    end
  end

  // Watchdog counter: cleared at launch, saturating count while waiting.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)                                 cnt_q <= '0;
    else if (state_q == S_START)                cnt_q <= '0;
    else if (state_q == S_WAIT && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)           sticky_q <= 1'b0;
    else if (timeout_hit) sticky_q <= 1'b1;
  end

  assign o_start_read_axi = start_pulse;
  assign o_grant          = grant_q;
  assign o_grant_id       = grant_id_q;
  assign o_busy           = (state_q != S_IDLE);
  assign o_read_last      = last_ok ? grant_q : '0;
  assign o_pending        = pending_q;
  assign o_timeout        = timeout_hit;
  assign o_timeout_sticky = sticky_q;

endmodule
